// File: rtl/ram8_8.sv
// Simple dual-port RAM (one write port, one registered read port) for single-clock datapaths.
// Reads are read-first on a same-address collision; reset clears every word and the read register.
module ram8_8 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_enb,
  input  logic                  rd_enb,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] data_out_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_enb) begin
      mem_d[wr_addr] = data_in;
    end
  end

  // Read port samples mem_q, i.e. the contents before this edge's write.
  always_comb begin
    data_out_d = data_out_q;
    if (rd_enb) begin
      data_out_d = mem_q[rd_addr];
    end
  end

  // Whole-array clear on reset keeps this in registers rather than block RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      data_out_q <= '0;
    end else begin
      mem_q      <= mem_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_ram8_8.sv
// Bench for ram8_8: directed vector table for the documented scenarios, then
// randomized traffic compared against an array-based reference model.
module tb_ram8_8;

  logic       clk;
  logic       rst;
  logic       wr_enb;
  logic       rd_enb;
  logic [2:0] wr_addr;
  logic [2:0] rd_addr;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int n_checks;
  int n_errors;

  typedef struct {
    logic       rst;
    logic       we;
    logic       re;
    logic [2:0] wa;
    logic [2:0] ra;
    logic [7:0] din;
    logic [7:0] exp_out;
    string      name;
  } vec_t;

  vec_t vecs[$];

  ram8_8 #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_enb   (wr_enb),
    .rd_enb   (rd_enb),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic we, input logic re,
                     input logic [2:0] wa, input logic [2:0] ra,
                     input logic [7:0] din, input logic [7:0] exp_out,
                     input string name);
    vec_t v;
    v.rst = r; v.we = we; v.re = re; v.wa = wa; v.ra = ra;
    v.din = din; v.exp_out = exp_out; v.name = name;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs, let the edge happen, sample 1 time unit later.
  task automatic step(input logic r, input logic we, input logic re,
                      input logic [2:0] wa, input logic [2:0] ra,
                      input logic [7:0] din);
    rst = r; wr_enb = we; rd_enb = re;
    wr_addr = wa; rd_addr = ra; data_in = din;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] exp_out);
    n_checks++;
    if (data_out !== exp_out) begin
      n_errors++;
      $display("FAIL %s: data_out=%02h expected=%02h", name, data_out, exp_out);
    end
  endtask

  logic [7:0] model_mem [8];
  logic [7:0] model_out;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; wr_enb = 1'b0; rd_enb = 1'b0;
    wr_addr = '0; rd_addr = '0; data_in = '0;

    // Reset held two edges, then read every address.
    add(1, 0, 0, 0, 0, 8'h00, 8'h00, "reset_edge0");
    add(1, 1, 1, 1, 1, 8'h5A, 8'h00, "reset_edge1");
    for (int i = 0; i < 8; i++) add(0, 0, 1, 0, 3'(i), 8'h00, 8'h00, "read_after_reset");
    // Basic write/read and hold.
    add(0, 1, 0, 4, 0, 8'd5,  8'h00, "write_a4");
    add(0, 1, 0, 5, 0, 8'd10, 8'h00, "write_a5");
    add(0, 0, 1, 0, 4, 8'h00, 8'd5,  "read_a4");
    add(0, 0, 1, 0, 5, 8'h00, 8'd10, "read_a5");
    add(0, 0, 0, 0, 4, 8'h00, 8'd10, "hold_rd_disabled");
    // Same-address collision is read-first.
    add(0, 1, 0, 2, 0, 8'h11, 8'd10, "write_a2_11");
    add(0, 1, 1, 2, 2, 8'h22, 8'h11, "collision_old");
    add(0, 0, 1, 0, 2, 8'h00, 8'h22, "collision_new");
    // Back-to-back sweep, then reverse read with no bubbles.
    for (int i = 0; i < 8; i++) add(0, 1, 0, 3'(i), 0, 8'(8'hA0 + i), 8'h22, "sweep_write");
    for (int i = 7; i >= 0; i--) add(0, 0, 1, 0, 3'(i), 8'h00, 8'(8'hA0 + i), "sweep_read");
    // Reset mid-stream discards the coincident write and read.
    add(1, 1, 1, 3, 5, 8'hFF, 8'h00, "reset_midstream");
    for (int i = 0; i < 8; i++) add(0, 0, 1, 0, 3'(i), 8'h00, 8'h00, "read_after_midreset");
    // First edge after reset release performs a write.
    add(0, 1, 1, 6, 6, 8'h3C, 8'h00, "release_write");
    add(0, 0, 1, 0, 6, 8'h00, 8'h3C, "release_readback");

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].we, vecs[k].re, vecs[k].wa, vecs[k].ra, vecs[k].din);
      check(vecs[k].name, vecs[k].exp_out);
    end

    // Hand sequence: reset while rd_enb stays low still clears data_out.
    step(0, 0, 1, 0, 6, 8'h00);
    check("pre_reset_hold", 8'h3C);
    step(1, 0, 0, 0, 0, 8'h00);
    check("reset_clears_out", 8'h00);

    // Randomized traffic against a plain array model.
    foreach (model_mem[i]) model_mem[i] = 8'h00;
    model_out = 8'h00;
    for (int n = 0; n < 400; n++) begin
      logic       r, we, re;
      logic [2:0] wa, ra;
      logic [7:0] din;
      r   = ($urandom_range(0, 39) == 0);
      we  = 1'($urandom);
      re  = 1'($urandom);
      wa  = 3'($urandom);
      ra  = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom);
      din = 8'($urandom);
      if (r) begin
        foreach (model_mem[i]) model_mem[i] = 8'h00;
        model_out = 8'h00;
      end else begin
        if (re) model_out = model_mem[ra];
        if (we) model_mem[wa] = din;
      end
      step(r, we, re, wa, ra, din);
      check("random", model_out);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
